// File: rtl/snd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : snd_pkg
//  Description : Shared constants and FSM state type for the DAC serialiser.
//  Revision    : 1.0  initial release
// ============================================================================
package snd_pkg;

    // Frame formats selectable through the MODE parameter
    localparam int MODE_FLOAT    = 0;
    localparam int MODE_LINEAR   = 1;

    // The YM3014 floating-point word is always 16 bits on the wire
    localparam int FLOAT_FRAME_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/snd_dac_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : snd_dac_tx_if
//  Description : Sample handshake and DAC serial bus of the DAC serialiser.
//                master = sample producer, slave = serialiser.
//  Revision    : 1.0  initial release
// ============================================================================
interface snd_dac_tx_if #(
    parameter int SAMPLE_BITS = 32
);
    logic [SAMPLE_BITS-1:0] iSample;
    logic                   iValid;
    logic                   oReady;
    logic                   oBusy;
    logic                   oDacClk;
    logic                   oDacSd;
    logic                   oDacLoad;

    modport master (
        output iSample, iValid,
        input  oReady, oBusy, oDacClk, oDacSd, oDacLoad
    );

    modport slave (
        input  iSample, iValid,
        output oReady, oBusy, oDacClk, oDacSd, oDacLoad
    );
endinterface
`default_nettype wire

// File: rtl/ym_float_enc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ym_float_enc
//  Description : Combinational YM3014 floating-point encoder. Normalises a
//                16-bit signed value by up to six sign-bit positions and
//                returns the 10-bit mantissa and 3-bit exponent.
//  Revision    : 1.0  initial release
// ============================================================================
module ym_float_enc
    import snd_pkg::*;
(
    input  logic [FLOAT_FRAME_W-1:0] iS,
    output logic [9:0]               oM,
    output logic [2:0]               oE
);

    logic [2:0]               w_k;
    logic                     w_run;
    logic [FLOAT_FRAME_W-1:0] w_sh;

    // Count leading copies of the sign bit in s[14:9], then normalise
    always_comb begin
        w_k   = 3'd0;
        w_run = 1'b1;
        for (int i = 14; i >= 9; i--) begin
            if (w_run && (iS[i] == iS[15])) begin
                w_k = w_k + 3'd1;
            end else begin
                w_run = 1'b0;
            end
        end
        w_sh = iS << w_k;
        oM   = w_sh[15:6];
        oE   = 3'd7 - w_k;
    end

endmodule
`default_nettype wire

// File: rtl/snd_dac_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : snd_dac_tx
//  Description : Serialises a multi-channel sample set to a serial DAC,
//                either as YM3014 floating-point frames or as linear
//                MSB-first words, paced by an external clock enable.
//  Revision    : 1.0  initial release
// ============================================================================
module snd_dac_tx
    import snd_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16,
    parameter int MODE     = 0,
    parameter int CLKDIV   = 2
) (
    input  logic                         iClk,
    input  logic                         iRstN,
    input  logic                         iClkEn,
    input  logic [CHANNELS*SAMPLE_W-1:0] iSample,
    input  logic                         iValid,
    output logic                         oReady,
    output logic                         oBusy,
    output logic                         oDacClk,
    output logic                         oDacSd,
    output logic                         oDacLoad
);

    localparam int FRAME_W = (MODE == MODE_FLOAT) ? FLOAT_FRAME_W : SAMPLE_W;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int CH_W    = $clog2(CHANNELS + 1);
    localparam int TICK_W  = $clog2(2 * CLKDIV);

    localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [CH_W-1:0]   c_CH_END    = CH_W'(CHANNELS);
    localparam logic [TICK_W-1:0] c_TICK_HI   = TICK_W'(CLKDIV);
    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(2 * CLKDIV - 1);

    state_t                       state_q;
    logic [CHANNELS*SAMPLE_W-1:0] sample_q;
    logic [FRAME_W-1:0]           sr_q;
    logic [BIT_W-1:0]             bit_q;
    logic [CH_W-1:0]              ch_q;
    logic [TICK_W-1:0]            tick_q;
    logic                         ready_q;
    logic                         busy_q;
    logic                         dclk_q;
    logic                         sd_q;
    logic                         load_q;

    logic [SAMPLE_W-1:0]          w_chan;
    logic [FRAME_W-1:0]           w_word;

    // Pick the latched sample of the channel currently being sent
    always_comb begin
        w_chan = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_q == CH_W'(i)) begin
                w_chan = sample_q[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Wire word for the selected channel, arranged so bit 0 goes out first
    generate
        if (MODE == MODE_FLOAT) begin : g_float
            logic [FLOAT_FRAME_W-1:0] w_top;
            logic [9:0]               w_m;
            logic [2:0]               w_e;

            if (SAMPLE_W >= FLOAT_FRAME_W) begin : g_trunc
                assign w_top = w_chan[SAMPLE_W-1 -: FLOAT_FRAME_W];
            end else begin : g_pad
                assign w_top = {w_chan, {(FLOAT_FRAME_W-SAMPLE_W){1'b0}}};
            end

            ym_float_enc u_enc (
                .iS (w_top),
                .oM (w_m),
                .oE (w_e)
            );

            assign w_word = {w_e, w_m, 3'b000};
        end else begin : g_linear
            // Bit-reverse so the sample MSB lands in the first-out position
            always_comb begin
                for (int i = 0; i < FRAME_W; i++) begin
                    w_word[i] = w_chan[FRAME_W-1-i];
                end
            end
        end
    endgenerate

    // Handshake, bit/tick sequencing and registered DAC pins
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q  <= ST_IDLE;
            sample_q <= '0;
            sr_q     <= '0;
            bit_q    <= '0;
            ch_q     <= '0;
            tick_q   <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            dclk_q   <= 1'b0;
            sd_q     <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iValid && ready_q) begin
                        sample_q <= iSample;
                        bit_q    <= '0;
                        ch_q     <= '0;
                        tick_q   <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (iClkEn) begin
                        if (tick_q == '0) begin
                            // Tick 0 ends the previous bit's high phase and
                            // starts the next bit, or closes the frame
                            if (ch_q == c_CH_END) begin
                                dclk_q  <= 1'b0;
                                sd_q    <= 1'b0;
                                load_q  <= 1'b0;
                                state_q <= ST_DONE;
                            end else begin
                                dclk_q <= 1'b0;
                                load_q <= (bit_q == c_BIT_LAST);
                                if (bit_q == '0) begin
                                    sd_q <= w_word[0];
                                    sr_q <= w_word >> 1;
                                end else begin
                                    sd_q <= sr_q[0];
                                    sr_q <= sr_q >> 1;
                                end
                                tick_q <= TICK_W'(1);
                            end
                        end else begin
                            if (tick_q == c_TICK_HI) begin
                                dclk_q <= 1'b1;
                            end
                            if (tick_q == c_TICK_LAST) begin
                                tick_q <= '0;
                                if (bit_q == c_BIT_LAST) begin
                                    bit_q <= '0;
                                    ch_q  <= ch_q + CH_W'(1);
                                end else begin
                                    bit_q <= bit_q + BIT_W'(1);
                                end
                            end else begin
                                tick_q <= tick_q + TICK_W'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign oReady   = ready_q;
    assign oBusy    = busy_q;
    assign oDacClk  = dclk_q;
    assign oDacSd   = sd_q;
    assign oDacLoad = load_q;

endmodule
`default_nettype wire
